// File: rtl/bias_relu.sv
// ---------------------------------------------------------------------------
// bias_relu
//
// Downstream stage of the matmul block. When `start` is sampled while not busy,
// the block captures the packed HxW single-precision matrix `x` and the
// per-column bias vector `bias`. It then walks the elements in index order,
// one per clock. For each element it adds the column bias with a truncating
// float adder. It can optionally clamp negative sums to +0 (ReLU) and writes
// the value into `o`. `done` is a level flag that rises on the edge that
// writes the last element. It stays high until the next accepted start.
//
// Parameters
//   S    : element width, must be 32 (IEEE-754 single)
//   H, W : matrix rows / columns (W is also the bias vector length)
//   RELU : 1 = negative sums (incl. -0, -inf) become +0, 0 = sum passed as-is
//
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; aborts any operation in progress
//   start : begin operation, honoured in IDLE and DONE, ignored in RUN
//   x     : packed matrix, element i = r*W+c at x[i*S +: S]
//   bias  : bias per column, column c at bias[c*S +: S]
//   o     : packed result, same layout as x
//   done  : high while o holds a complete result
// ---------------------------------------------------------------------------
module bias_relu #(
  parameter int S    = 32,
  parameter int H    = 2,
  parameter int W    = 2,
  parameter int RELU = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [H*W*S-1:0] x,
  input  logic [W*S-1:0]   bias,
  output logic [H*W*S-1:0] o,
  output logic             done
);

  localparam int N    = H * W;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int COLW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  // The column index is tracked alongside the element counter. This avoids a
  // modulo-W operation on the counter.
  logic [COLW-1:0]  col;
  logic [N*S-1:0]   x_lat;
  logic [W*S-1:0]   bias_lat;

  logic             load;
  logic             last;
  logic [31:0]      elem_sum;
  logic [31:0]      elem_out;

  // -------------------------------------------------------------------------
  // Truncating single-precision adder.
  // Denormal inputs are flushed to zero. The smaller operand is aligned with
  // three guard bits and no sticky bit. The result is truncated toward zero.
  // If either input has exponent 255, the result is the canonical NaN.
  // -------------------------------------------------------------------------
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  ea, eb, e_big, e_sml, d;
    logic [26:0] ma, mb, m_big, m_sml, m_shift;
    logic        s_big, s_sml;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  e_res;
    logic [22:0] frac;

    ea = a[30:23];
    eb = b[30:23];
    ma = (ea == 8'd0) ? 27'd0 : {1'b1, a[22:0], 3'b000};
    mb = (eb == 8'd0) ? 27'd0 : {1'b1, b[22:0], 3'b000};

    // Order the operands by magnitude so the subtraction below never goes
    // negative. The sign of the result is then the sign of the larger one.
    if ({ea, ma} >= {eb, mb}) begin
      e_big = ea; m_big = ma; s_big = a[31];
      e_sml = eb; m_sml = mb; s_sml = b[31];
    end else begin
      e_big = eb; m_big = mb; s_big = b[31];
      e_sml = ea; m_sml = ma; s_sml = a[31];
    end

    d       = e_big - e_sml;
    m_shift = (d >= 8'd27) ? 27'd0 : (m_sml >> d);

    if (s_big == s_sml) sum = {1'b0, m_big} + {1'b0, m_shift};
    else                sum = {1'b0, m_big} - {1'b0, m_shift};

    // Leading-zero count over the 27-bit field. The highest set bit wins.
    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end

    if (sum[27]) begin
      e_res = {2'b00, e_big} + 10'd1;
      frac  = 23'(sum >> 4);
    end else begin
      // If the exponent borrows below zero, it wraps into bit 9. That case is
      // treated as underflow below.
      e_res = {2'b00, e_big} - {5'd0, lz};
      frac  = 23'((sum[26:0] << lz) >> 3);
    end

    if (ea == 8'hFF || eb == 8'hFF)        fadd = 32'h7FC0_0000;
    else if (sum == 28'd0)                 fadd = 32'h0000_0000;
    else if (e_res[9] || e_res == 10'd0)   fadd = 32'h0000_0000;
    else if (e_res > 10'd254)              fadd = {s_big, 8'hFF, 23'd0};
    else                                   fadd = {s_big, e_res[7:0], frac};
  endfunction

  assign load     = start && (state != RUN);
  assign last     = (cnt == CW'(N - 1));
  assign elem_sum = fadd(x_lat[cnt*S +: S], bias_lat[col*S +: S]);
  assign elem_out = ((RELU != 0) && elem_sum[31]) ? 32'h0000_0000 : elem_sum;

  // NOTE: the operand copies are plain data registers. They are written only
  // on an accepted start and read only in RUN. A reset on them would add
  // routing and change no observable behaviour, so they have none.
  always_ff @(posedge clk) begin
    if (load) begin
      x_lat    <= x;
      bias_lat <= bias;
    end
  end

  // NOTE: all state here uses non-blocking assignments. Every register then
  // sees the pre-edge values of the others, e.g. the element write uses the
  // same cnt that is being incremented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      col   <= '0;
      o     <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            cnt   <= '0;
            col   <= '0;
            done  <= 1'b0;
          end
        end
        RUN: begin
          o[cnt*S +: S] <= elem_out;
          if (last) begin
            done  <= 1'b1;
            state <= DONE;
            cnt   <= '0;
            col   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            col <= (col == COLW'(W - 1)) ? '0 : col + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_relu.sv
module tb_bias_relu;

  localparam int H = 2;
  localparam int W = 2;
  localparam int N = H * W;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [N*32-1:0]  x;
  logic [W*32-1:0]  bias;
  logic [N*32-1:0]  o_r, o_p;
  logic             done_r, done_p;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_r [N];
  logic [31:0] exp_p [N];
  logic [31:0] prev_r[N];
  logic [31:0] prev_p[N];

  bias_relu #(.S(32), .H(H), .W(W), .RELU(1)) dut_relu (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .bias(bias),
    .o(o_r), .done(done_r)
  );

  bias_relu #(.S(32), .H(H), .W(W), .RELU(0)) dut_pass (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .bias(bias),
    .o(o_p), .done(done_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference adder: exact integer arithmetic on the scaled significands.
  // The smaller operand is aligned with 3 guard bits, and the result is
  // truncated and renormalised.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    longint ma, mb, mag_big, mag_sml, r;
    int ea, eb, e_big, e_sml, e;
    bit s_big, s_sml, sg;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) return 32'h7FC00000;
    ma = (ea == 0) ? 0 : longint'({1'b1, a[22:0]}) * 8;
    mb = (eb == 0) ? 0 : longint'({1'b1, b[22:0]}) * 8;
    if (ea > eb || (ea == eb && ma >= mb)) begin
      e_big = ea; mag_big = ma; s_big = a[31]; e_sml = eb; mag_sml = mb; s_sml = b[31];
    end else begin
      e_big = eb; mag_big = mb; s_big = b[31]; e_sml = ea; mag_sml = ma; s_sml = a[31];
    end
    if (e_big - e_sml >= 27) mag_sml = 0;
    else mag_sml = mag_sml / (longint'(1) << (e_big - e_sml));
    r = (s_big ? -mag_big : mag_big) + (s_sml ? -mag_sml : mag_sml);
    if (r == 0) return 32'h00000000;
    sg = (r < 0);
    if (sg) r = -r;
    e = e_big;
    while (r >= 2**27) begin r = r / 2; e++; end
    while (r < 2**26)  begin r = r * 2; e--; end
    if (e < 1)   return 32'h00000000;
    if (e > 254) return {sg, 8'hFF, 23'd0};
    return {sg, 8'(e), 23'(r >> 3)};
  endfunction

  function automatic logic [31:0] rand_fp();
    int sel;
    logic [7:0] e;
    sel = $urandom_range(0, 99);
    if (sel < 8)       e = 8'd0;
    else if (sel < 12) e = 8'd255;
    else if (sel < 20) e = 8'($urandom_range(245, 254));
    else               e = 8'($urandom_range(110, 140));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic check_outputs(input string tag);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_relu_e%0d", tag, k), o_r[k*32 +: 32], exp_r[k]);
      check($sformatf("%s_pass_e%0d", tag, k), o_p[k*32 +: 32], exp_p[k]);
    end
  endtask

  // A full operation. Inputs are scrambled after the start edge to confirm
  // they were captured. A start pulse is sampled at RUN edge `pulse_at`
  // (0 = none).
  task automatic run_op(input string tag, input logic [N*32-1:0] xv,
                        input logic [W*32-1:0] bv, input int pulse_at);
    logic [31:0] s;
    for (int k = 0; k < N; k++) begin
      s = ref_add(xv[k*32 +: 32], bv[(k % W)*32 +: 32]);
      exp_p[k] = s;
      exp_r[k] = s[31] ? 32'h00000000 : s;
    end
    @(negedge clk);
    x = xv; bias = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x = {$urandom, $urandom, $urandom, $urandom};
    bias = {$urandom, $urandom};
    check({tag, "_done_low_r"}, 32'(done_r), 32'd0);
    check({tag, "_done_low_p"}, 32'(done_p), 32'd0);
    for (int j = 1; j <= N; j++) begin
      if (j == pulse_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (j == 1) begin
        check({tag, "_held_last_r"}, o_r[(N-1)*32 +: 32], prev_r[N-1]);
        check({tag, "_held_last_p"}, o_p[(N-1)*32 +: 32], prev_p[N-1]);
      end
      check($sformatf("%s_done_r_edge%0d", tag, j), 32'(done_r), 32'(j == N));
      check($sformatf("%s_done_p_edge%0d", tag, j), 32'(done_p), 32'(j == N));
    end
    check_outputs(tag);
    for (int k = 0; k < N; k++) begin
      prev_r[k] = exp_r[k];
      prev_p[k] = exp_p[k];
    end
  endtask

  function automatic logic [N*32-1:0] rep_x(input logic [31:0] v);
    logic [N*32-1:0] r;
    for (int k = 0; k < N; k++) r[k*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [W*32-1:0] rep_b(input logic [31:0] v);
    logic [W*32-1:0] r;
    for (int c = 0; c < W; c++) r[c*32 +: 32] = v;
    return r;
  endfunction

  logic [N*32-1:0] xv;
  logic [W*32-1:0] bv;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    x     = '0;
    bias  = '0;
    for (int k = 0; k < N; k++) begin prev_r[k] = '0; prev_p[k] = '0; end
    #12;
    for (int k = 0; k < N; k++) begin
      check($sformatf("reset_o_r_e%0d", k), o_r[k*32 +: 32], 32'h0);
      check($sformatf("reset_o_p_e%0d", k), o_p[k*32 +: 32], 32'h0);
    end
    check("reset_done_r", 32'(done_r), 32'd0);
    check("reset_done_p", 32'(done_p), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 5.0 + 5.0 = 10.0
    run_op("five", rep_x(32'h40A00000), rep_b(32'h40A00000), 0);
    check("five_const", o_r[0 +: 32], 32'h41200000);

    // 5 + -7 = -2, clamped by ReLU. The start lands in DONE.
    xv = rep_x(32'h40A00000);
    xv[3*32 +: 32] = 32'hC0E00000;
    run_op("neg", xv, rep_b(32'h40A00000), 0);
    check("neg_relu_const", o_r[3*32 +: 32], 32'h00000000);
    check("neg_pass_const", o_p[3*32 +: 32], 32'hC0000000);

    // Exact cancellation. A start pulse mid-RUN is ignored.
    run_op("cancel", rep_x(32'h3FC00000), rep_b(32'hBFC00000), 2);
    check("cancel_const", o_p[1*32 +: 32], 32'h00000000);

    // Truncation: 1.0 + 2^-24 stays 1.0.
    run_op("trunc", rep_x(32'h3F800000), rep_b(32'h33800000), 0);
    check("trunc_const", o_p[2*32 +: 32], 32'h3F800000);

    // Overflow to +inf.
    run_op("ovf", rep_x(32'h7F7FFFFF), rep_b(32'h7F7FFFFF), 0);
    check("ovf_const", o_r[0 +: 32], 32'h7F800000);

    // Denormal input is flushed to zero.
    run_op("denorm", rep_x(32'h00400000), rep_b(32'h40A00000), 0);
    check("denorm_const", o_p[3*32 +: 32], 32'h40A00000);

    // Column indexing: col0 bias 1.0, col1 bias 2.0.
    bv = {32'h40000000, 32'h3F800000};
    run_op("col", rep_x(32'h3F800000), bv, 3);
    check("col_c0_const", o_r[0 +: 32], 32'h40000000);
    check("col_c1_const", o_r[1*32 +: 32], 32'h40400000);

    // DONE holds o and done without a start.
    repeat (3) @(negedge clk);
    check("hold_done_r", 32'(done_r), 32'd1);
    check_outputs("hold");

    // Asynchronous reset between edges mid-RUN.
    @(negedge clk);
    x = rep_x(32'h40A00000); bias = rep_b(32'h3F800000); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      check($sformatf("areset_o_r_e%0d", k), o_r[k*32 +: 32], 32'h0);
      check($sformatf("areset_o_p_e%0d", k), o_p[k*32 +: 32], 32'h0);
    end
    check("areset_done_r", 32'(done_r), 32'd0);
    check("areset_done_p", 32'(done_p), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) begin prev_r[k] = '0; prev_p[k] = '0; end
    run_op("after_rst", rep_x(32'h40A00000), rep_b(32'h40A00000), 0);

    // Randomised operands. Some bias values are forced to be the negation of
    // an element to exercise cancellation.
    for (int t = 0; t < 60; t++) begin
      for (int k = 0; k < N; k++) xv[k*32 +: 32] = rand_fp();
      for (int c = 0; c < W; c++) bv[c*32 +: 32] = rand_fp();
      if ($urandom_range(0, 99) < 20) bv[0 +: 32] = xv[0 +: 32] ^ 32'h80000000;
      if ($urandom_range(0, 99) < 20) bv[32 +: 32] = {~xv[63], xv[62:55], 23'($urandom)};
      run_op($sformatf("rnd%0d", t), xv, bv, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N)) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
